reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
Receiving end of the instruction decoder's dispatch interface. Buffers decoded instructions steered to one station ID and tracks operand readiness by tag. Captures results broadcast on the common data bus (CDB). Issues the oldest fully-ready entry to its functional unit over a valid/ready handshake. One instance is placed per station ID (1 = int ALU, 2 = mul/div, 3 = branch/lui, 4 = load/store).

Parameters:
DEPTH, 4, number of entries (power of two, 2..16)
TAG_W, 4, physical tag width
STATION_ID, 1, rs_station value this instance accepts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries (mispredict)
disp_valid  in  1  decoded instruction present
disp_rs_station  in  4  target station from decoder
disp_is_noop  in  1  decoder no-op flag
disp_ready  out  1  at least one free entry
disp_alu_fn  in  6  decoder alu_fn
disp_immediate  in  16  decoder immediate
disp_has_src1 / disp_has_src2  in  1  operand used
disp_src1_rdy / disp_src2_rdy  in  1  operand value already valid
disp_src1_val / disp_src2_val  in  32  operand value when rdy
disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when not rdy
disp_dest_tag  in  TAG_W  result tag
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  32  broadcast value
iss_valid  out  1  issue candidate present
iss_ready  in  1  functional unit accepts
iss_alu_fn  out  6  issued alu_fn
iss_op1 / iss_op2  out  32  operand values
iss_immediate  out  16  issued immediate
iss_dest_tag  out  TAG_W  issued result tag

Behaviour:
- Reset (rst_n low, async): all entry valid bits cleared, age state cleared. Outputs: iss_valid=0, disp_ready=1, all iss_* data outputs 0.
- Accept condition: disp_valid && disp_ready && disp_rs_station==STATION_ID && !disp_is_noop. Any other dispatch is ignored with no state change. disp_ready depends only on current valid bits, never on disp_*.
- On accept, the lowest-index free entry is written at the clock edge.
- Per-operand state on accept:
  - has_src=0: operand ready, value 0.
  - rdy=1: value captured, operand ready.
  - Else: tag stored, operand waiting.
- Same-cycle bypass: if cdb_valid and cdb_tag equals a waiting dispatched tag, the operand is stored ready with cdb_value.
- Wakeup: each cycle, every valid entry with a waiting operand whose tag equals cdb_tag (cdb_valid=1) captures cdb_value and becomes ready at the edge. Both operands of one entry may wake together.
- Entry readiness: an entry is ready when valid and both operands are ready.
- Issue selection (combinational from registered state):
  - iss_valid=1 when any entry is ready; iss_* show the oldest ready entry in dispatch order.
  - Oldest is tracked by an age matrix or per-entry sequence counter. Index order must not be used.
  - Data outputs are 0 when iss_valid=0.
- Issue handshake: iss_valid && iss_ready frees the selected entry at the edge. At most one issue per cycle. While iss_valid=1 and iss_ready=0, the selection may change only if an older entry becomes ready.
- Latency:
  - Dispatch with all operands ready → iss_valid the next cycle.
  - CDB wakeup → iss_valid the cycle after the broadcast.
- Full: when all DEPTH entries are valid, disp_ready=0. An entry freed by issue in cycle N is available to dispatch in cycle N+1. No same-cycle reuse.
- Simultaneous dispatch + issue + CDB in one cycle are all honoured; the CDB applies to both existing and incoming entries.
- Flush: clears all valid bits at the edge and overrides dispatch, wakeup and issue in that cycle. iss_valid=0 the following cycle.
- Reset mid-operation: all in-flight entries are lost and outputs return to reset values immediately.

Test Plan:
- Reset, then dispatch addiu-like entry (STATION_ID=1, src1 rdy val=5, imm=0x0010, dest_tag=3) → next cycle iss_valid=1, iss_op1=5, iss_op2=0, iss_immediate=0x0010, iss_dest_tag=3. With iss_ready=1, iss_valid=0 the following cycle.
- Dispatch entry with src1 waiting tag=7, then cdb_valid tag=7 value=0xDEADBEEF two cycles later → iss_valid rises the cycle after the broadcast, iss_op1=0xDEADBEEF. Repeat with CDB in the dispatch cycle → iss_valid the next cycle.
- Fill 4 entries with iss_ready=0 → disp_ready=0 and a 5th dispatch is dropped. Issue one → disp_ready=1 the next cycle and a new dispatch is accepted.
- Dispatch A (waiting tag=2) then B (ready), then wake A via CDB with iss_ready=0 → both ready, iss_* show A (oldest). After A issues, B issues.
- Dispatch with disp_rs_station=2 or disp_is_noop=1 to a STATION_ID=1 instance → no entry allocated, iss_valid stays 0.
- Three valid entries, assert flush together with a dispatch and a CDB → next cycle iss_valid=0, disp_ready=1, no entries remain.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops, wakes operands from the CDB and issues the oldest ready entry.
// Issue is one cycle after the last operand arrives; disp_ready drops only when every entry is valid.
module reservation_station #(
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4,
    parameter int STATION_ID = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [3:0]       disp_rs_station,
    input  logic             disp_is_noop,
    output logic             disp_ready,
    input  logic [5:0]       disp_alu_fn,
    input  logic [15:0]      disp_immediate,
    input  logic             disp_has_src1,
    input  logic             disp_has_src2,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [31:0]      disp_src1_val,
    input  logic [31:0]      disp_src2_val,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [TAG_W-1:0] disp_dest_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [5:0]       iss_alu_fn,
    output logic [31:0]      iss_op1,
    output logic [31:0]      iss_op2,
    output logic [15:0]      iss_immediate,
    output logic [TAG_W-1:0] iss_dest_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0] s2_rdy_q, s2_rdy_d;
    logic [31:0]      s1_val_q [DEPTH];
    logic [31:0]      s1_val_d [DEPTH];
    logic [31:0]      s2_val_q [DEPTH];
    logic [31:0]      s2_val_d [DEPTH];
    logic [TAG_W-1:0] s1_tag_q [DEPTH];
    logic [TAG_W-1:0] s1_tag_d [DEPTH];
    logic [TAG_W-1:0] s2_tag_q [DEPTH];
    logic [TAG_W-1:0] s2_tag_d [DEPTH];
    logic [5:0]       fn_q     [DEPTH];
    logic [5:0]       fn_d     [DEPTH];
    logic [15:0]      imm_q    [DEPTH];
    logic [15:0]      imm_d    [DEPTH];
    logic [TAG_W-1:0] dest_q   [DEPTH];
    logic [TAG_W-1:0] dest_d   [DEPTH];
    // older_q[j][i] set means entry j was dispatched before entry i
    logic [DEPTH-1:0] older_q  [DEPTH];
    logic [DEPTH-1:0] older_d  [DEPTH];

    logic             accept;
    logic             do_issue;
    logic [IDX_W-1:0] free_idx;
    logic [DEPTH-1:0] ent_rdy;
    logic [DEPTH-1:0] sel_oh;
    logic             in1_rdy, in2_rdy;
    logic [31:0]      in1_val, in2_val;

    assign disp_ready = ~&valid_q;
    assign accept     = disp_valid && disp_ready && (disp_rs_station == 4'(STATION_ID)) && !disp_is_noop;
    assign ent_rdy    = valid_q & s1_rdy_q & s2_rdy_q;
    assign iss_valid  = |ent_rdy;
    assign do_issue   = iss_valid && iss_ready;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // An entry is selected when no other ready entry is older than it.
    always_comb begin
        sel_oh = ent_rdy;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ent_rdy[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
    end

    always_comb begin
        iss_alu_fn    = '0;
        iss_op1       = '0;
        iss_op2       = '0;
        iss_immediate = '0;
        iss_dest_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                iss_alu_fn    = fn_q[i];
                iss_op1       = s1_val_q[i];
                iss_op2       = s2_val_q[i];
                iss_immediate = imm_q[i];
                iss_dest_tag  = dest_q[i];
            end
        end
    end

    // Incoming operands, including a same-cycle CDB bypass for waiting tags.
    always_comb begin
        in1_rdy = 1'b1;
        in1_val = '0;
        in2_rdy = 1'b1;
        in2_val = '0;
        if (disp_has_src1) begin
            if (disp_src1_rdy)                               in1_val = disp_src1_val;
            else if (cdb_valid && cdb_tag == disp_src1_tag) in1_val = cdb_value;
            else                                             in1_rdy = 1'b0;
        end
        if (disp_has_src2) begin
            if (disp_src2_rdy)                               in2_val = disp_src2_val;
            else if (cdb_valid && cdb_tag == disp_src2_tag) in2_val = cdb_value;
            else                                             in2_rdy = 1'b0;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        s1_val_d = s1_val_q;
        s2_val_d = s2_val_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        fn_d     = fn_q;
        imm_d    = imm_q;
        dest_d   = dest_q;
        older_d  = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_valid) begin
                if (!s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = cdb_value;
                end
                if (!s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = cdb_value;
                end
            end
            if (do_issue && sel_oh[i]) valid_d[i] = 1'b0;
            if (accept && free_idx == IDX_W'(i)) begin
                valid_d[i]  = 1'b1;
                s1_rdy_d[i] = in1_rdy;
                s1_val_d[i] = in1_val;
                s1_tag_d[i] = disp_src1_tag;
                s2_rdy_d[i] = in2_rdy;
                s2_val_d[i] = in2_val;
                s2_tag_d[i] = disp_src2_tag;
                fn_d[i]     = disp_alu_fn;
                imm_d[i]    = disp_immediate;
                dest_d[i]   = disp_dest_tag;
                // The newcomer is younger than every other slot; stale rows are rewritten on reuse.
                older_d[i]  = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i) older_d[j][i] = 1'b1;
                end
            end
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                fn_q[i]     <= '0;
                imm_q[i]    <= '0;
                dest_q[i]   <= '0;
                older_q[i]  <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            s1_val_q <= s1_val_d;
            s2_val_q <= s2_val_d;
            s1_tag_q <= s1_tag_d;
            s2_tag_q <= s2_tag_d;
            fn_q     <= fn_d;
            imm_q    <= imm_d;
            dest_q   <= dest_d;
            older_q  <= older_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic against a dispatch-order queue model.
module tb_reservation_station;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             disp_valid;
    logic [3:0]       disp_rs_station;
    logic             disp_is_noop;
    logic             disp_ready;
    logic [5:0]       disp_alu_fn;
    logic [15:0]      disp_immediate;
    logic             disp_has_src1, disp_has_src2;
    logic             disp_src1_rdy, disp_src2_rdy;
    logic [31:0]      disp_src1_val, disp_src2_val;
    logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dest_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             iss_valid;
    logic             iss_ready;
    logic [5:0]       iss_alu_fn;
    logic [31:0]      iss_op1, iss_op2;
    logic [15:0]      iss_immediate;
    logic [TAG_W-1:0] iss_dest_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .STATION_ID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_rs_station(disp_rs_station), .disp_is_noop(disp_is_noop),
        .disp_ready(disp_ready), .disp_alu_fn(disp_alu_fn), .disp_immediate(disp_immediate),
        .disp_has_src1(disp_has_src1), .disp_has_src2(disp_has_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag), .disp_dest_tag(disp_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_fn(iss_alu_fn),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_immediate(iss_immediate), .iss_dest_tag(iss_dest_tag)
    );

    // Reference model: live entries kept in dispatch order, oldest first.
    typedef struct {
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [3:0]  dest;
        bit          r1, r2;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
    } ent_t;
    ent_t mq[$];

    function automatic int exp_sel();
        for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic logic [91:0] exp_vec();
        int   s   = exp_sel();
        logic rdy = (mq.size() < DEPTH);
        if (s < 0) return {1'b0, rdy, 90'd0};
        return {1'b1, rdy, mq[s].fn, mq[s].v1, mq[s].v2, mq[s].imm, mq[s].dest};
    endfunction

    task automatic model_step();
        int   s;
        bit   acc;
        ent_t e;
        if (!rst_n || flush) begin
            mq.delete();
            return;
        end
        s   = exp_sel();
        acc = disp_valid && (mq.size() < DEPTH) && disp_rs_station == 4'd1 && !disp_is_noop;
        if (cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (!e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.v1 = cdb_value; end
                if (!e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.v2 = cdb_value; end
                mq[i] = e;
            end
        end
        if (s >= 0 && iss_ready) mq.delete(s);
        if (acc) begin
            e.fn   = disp_alu_fn;
            e.imm  = disp_immediate;
            e.dest = disp_dest_tag;
            e.t1   = disp_src1_tag;
            e.t2   = disp_src2_tag;
            e.r1   = !disp_has_src1 || disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
            e.r2   = !disp_has_src2 || disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
            e.v1   = !disp_has_src1 ? 32'd0 : (disp_src1_rdy ? disp_src1_val : cdb_value);
            e.v2   = !disp_has_src2 ? 32'd0 : (disp_src2_rdy ? disp_src2_val : cdb_value);
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        disp_valid = 0;
        cdb_valid  = 0;
        flush      = 0;
    endtask

    task automatic idle_inputs();
        flush = 0; disp_valid = 0; disp_rs_station = 4'd1; disp_is_noop = 0;
        disp_alu_fn = '0; disp_immediate = '0;
        disp_has_src1 = 0; disp_has_src2 = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        disp_src1_val = '0; disp_src2_val = '0; disp_src1_tag = '0; disp_src2_tag = '0; disp_dest_tag = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0; iss_ready = 0;
    endtask

    task automatic drive_disp(input logic [5:0] fn, input logic [15:0] imm,
                              input logic h1, input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                              input logic h2, input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                              input logic [3:0] dest);
        disp_valid = 1; disp_rs_station = 4'd1; disp_is_noop = 0;
        disp_alu_fn = fn; disp_immediate = imm;
        disp_has_src1 = h1; disp_src1_rdy = r1; disp_src1_val = v1; disp_src1_tag = t1;
        disp_has_src2 = h2; disp_src2_rdy = r2; disp_src2_val = v2; disp_src2_tag = t2;
        disp_dest_tag = dest;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #12;
        checks++;
        if ({iss_valid, disp_ready, iss_alu_fn, iss_op1, iss_op2, iss_immediate, iss_dest_tag} !== {1'b0, 1'b1, 90'd0}) begin
            errors++;
            $display("FAIL reset_state got vld=%0b rdy=%0b op1=%h exp vld=0 rdy=1 data=0", iss_valid, disp_ready, iss_op1);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_addiu();
        drive_disp(6'h09, 16'h0010, 1, 1, 32'd5, 4'd0, 0, 0, 32'd0, 4'd0, 4'd3);
        checks++;
        if (iss_valid !== 1'b0) begin errors++; $display("FAIL addiu_pre got %0b exp 0", iss_valid); end
        tick();
        checks++;
        if ({iss_valid, iss_alu_fn, iss_op1, iss_op2, iss_immediate, iss_dest_tag} !== {1'b1, 6'h09, 32'd5, 32'd0, 16'h0010, 4'd3}) begin
            errors++;
            $display("FAIL addiu_issue got vld=%0b op1=%h op2=%h imm=%h dest=%0d exp 1/5/0/0010/3",
                     iss_valid, iss_op1, iss_op2, iss_immediate, iss_dest_tag);
        end
        iss_ready = 1;
        tick();
        iss_ready = 0;
        checks++;
        if (iss_valid !== 1'b0) begin errors++; $display("FAIL addiu_drain got %0b exp 0", iss_valid); end
    endtask

    task automatic test_wakeup();
        drive_disp(6'h01, 16'h0, 1, 0, 32'd0, 4'd7, 0, 0, 32'd0, 4'd0, 4'd4);
        tick();
        tick();
        checks++;
        if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0b exp 0", iss_valid); end
        cdb_valid = 1; cdb_tag = 4'd7; cdb_value = 32'hDEADBEEF;
        tick();
        checks++;
        if ({iss_valid, iss_op1, iss_dest_tag} !== {1'b1, 32'hDEADBEEF, 4'd4}) begin
            errors++;
            $display("FAIL wake_cdb got vld=%0b op1=%h dest=%0d exp 1/deadbeef/4", iss_valid, iss_op1, iss_dest_tag);
        end
        iss_ready = 1; tick(); iss_ready = 0;
        drive_disp(6'h02, 16'h0, 1, 0, 32'd0, 4'd9, 0, 0, 32'd0, 4'd0, 4'd8);
        cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'h00001234;
        tick();
        checks++;
        if ({iss_valid, iss_op1, iss_dest_tag} !== {1'b1, 32'h00001234, 4'd8}) begin
            errors++;
            $display("FAIL wake_bypass got vld=%0b op1=%h dest=%0d exp 1/1234/8", iss_valid, iss_op1, iss_dest_tag);
        end
        iss_ready = 1; tick(); iss_ready = 0;
        drive_disp(6'h03, 16'h0, 1, 0, 32'd0, 4'd5, 1, 0, 32'd0, 4'd5, 4'd2);
        tick();
        cdb_valid = 1; cdb_tag = 4'd5; cdb_value = 32'h55;
        tick();
        checks++;
        if ({iss_valid, iss_op1, iss_op2} !== {1'b1, 32'h55, 32'h55}) begin
            errors++;
            $display("FAIL wake_both got vld=%0b op1=%h op2=%h exp 1/55/55", iss_valid, iss_op1, iss_op2);
        end
        iss_ready = 1; tick(); iss_ready = 0;
    endtask

    task automatic test_full();
        int exp_ops[4] = '{101, 102, 103, 555};
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(6'h04, 16'h0, 1, 1, 32'(100 + i), 4'd0, 0, 0, 32'd0, 4'd0, 4'(i));
            tick();
        end
        checks++;
        if ({disp_ready, iss_op1} !== {1'b0, 32'd100}) begin
            errors++; $display("FAIL full_state got rdy=%0b op1=%0d exp 0/100", disp_ready, iss_op1);
        end
        drive_disp(6'h04, 16'h0, 1, 1, 32'd999, 4'd0, 0, 0, 32'd0, 4'd0, 4'd9);
        tick();
        iss_ready = 1;
        drive_disp(6'h04, 16'h0, 1, 1, 32'd777, 4'd0, 0, 0, 32'd0, 4'd0, 4'd7);
        tick();
        iss_ready = 0;
        checks++;
        if ({disp_ready, iss_op1} !== {1'b1, 32'd101}) begin
            errors++; $display("FAIL full_free got rdy=%0b op1=%0d exp 1/101", disp_ready, iss_op1);
        end
        drive_disp(6'h04, 16'h0, 1, 1, 32'd555, 4'd0, 0, 0, 32'd0, 4'd0, 4'd5);
        tick();
        checks++;
        if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_refill got %0b exp 0", disp_ready); end
        iss_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({iss_valid, iss_op1} !== {1'b1, 32'(exp_ops[i])}) begin
                errors++; $display("FAIL full_drain%0d got vld=%0b op1=%0d exp 1/%0d", i, iss_valid, iss_op1, exp_ops[i]);
            end
            tick();
        end
        iss_ready = 0;
        checks++;
        if (iss_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b exp 0", iss_valid); end
    endtask

    task automatic test_age();
        drive_disp(6'h05, 16'h0, 1, 0, 32'd0, 4'd2, 0, 0, 32'd0, 4'd0, 4'd5);
        tick();
        drive_disp(6'h06, 16'h0, 1, 1, 32'hB, 4'd0, 0, 0, 32'd0, 4'd0, 4'd6);
        tick();
        checks++;
        if ({iss_valid, iss_dest_tag} !== {1'b1, 4'd6}) begin
            errors++; $display("FAIL age_young got vld=%0b dest=%0d exp 1/6", iss_valid, iss_dest_tag);
        end
        cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'hA;
        tick();
        checks++;
        if ({iss_valid, iss_dest_tag, iss_op1} !== {1'b1, 4'd5, 32'hA}) begin
            errors++; $display("FAIL age_oldest got vld=%0b dest=%0d op1=%h exp 1/5/a", iss_valid, iss_dest_tag, iss_op1);
        end
        iss_ready = 1;
        tick();
        checks++;
        if ({iss_valid, iss_dest_tag} !== {1'b1, 4'd6}) begin
            errors++; $display("FAIL age_second got vld=%0b dest=%0d exp 1/6", iss_valid, iss_dest_tag);
        end
        tick();
        iss_ready = 0;
        checks++;
        if (iss_valid !== 1'b0) begin errors++; $display("FAIL age_empty got %0b exp 0", iss_valid); end
    endtask

    task automatic test_filter();
        drive_disp(6'h07, 16'h0, 1, 1, 32'd1, 4'd0, 0, 0, 32'd0, 4'd0, 4'd1);
        disp_rs_station = 4'd2;
        tick();
        checks++;
        if ({iss_valid, disp_ready} !== 2'b01) begin
            errors++; $display("FAIL filter_station got vld=%0b rdy=%0b exp 0/1", iss_valid, disp_ready);
        end
        drive_disp(6'h07, 16'h0, 1, 1, 32'd1, 4'd0, 0, 0, 32'd0, 4'd0, 4'd1);
        disp_is_noop = 1;
        tick();
        disp_is_noop = 0;
        checks++;
        if ({iss_valid, disp_ready} !== 2'b01) begin
            errors++; $display("FAIL filter_noop got vld=%0b rdy=%0b exp 0/1", iss_valid, disp_ready);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive_disp(6'h08, 16'h0, 1, 1, 32'(i), 4'd0, 0, 0, 32'd0, 4'd0, 4'(i));
            tick();
        end
        checks++;
        if ({iss_valid, disp_ready} !== 2'b11) begin
            errors++; $display("FAIL flush_pre got vld=%0b rdy=%0b exp 1/1", iss_valid, disp_ready);
        end
        drive_disp(6'h08, 16'h0, 1, 1, 32'd9, 4'd0, 0, 0, 32'd0, 4'd0, 4'd9);
        cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h1;
        flush = 1;
        tick();
        checks++;
        if ({iss_valid, disp_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_post got vld=%0b rdy=%0b exp 0/1", iss_valid, disp_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive_disp(6'h08, 16'h0, 1, 1, 32'(i), 4'd0, 0, 0, 32'd0, 4'd0, 4'(i));
            tick();
        end
        checks++;
        if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got rdy=%0b exp 1", disp_ready); end
        flush = 1;
        tick();
    endtask

    task automatic test_random();
        logic [91:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            disp_valid      = 1'($urandom_range(0, 1));
            disp_rs_station = ($urandom_range(0, 5) == 0) ? 4'd2 : 4'd1;
            disp_is_noop    = ($urandom_range(0, 7) == 0);
            disp_alu_fn     = 6'($urandom);
            disp_immediate  = 16'($urandom);
            disp_has_src1   = ($urandom_range(0, 3) != 0);
            disp_has_src2   = ($urandom_range(0, 3) != 0);
            disp_src1_rdy   = 1'($urandom_range(0, 1));
            disp_src2_rdy   = 1'($urandom_range(0, 1));
            disp_src1_val   = $urandom;
            disp_src2_val   = $urandom;
            disp_src1_tag   = 4'($urandom_range(0, 3));
            disp_src2_tag   = 4'($urandom_range(0, 3));
            disp_dest_tag   = 4'($urandom);
            cdb_valid       = ($urandom_range(0, 2) != 0);
            cdb_tag         = 4'($urandom_range(0, 3));
            cdb_value       = $urandom;
            iss_ready       = ($urandom_range(0, 2) == 0);
            flush           = ($urandom_range(0, 63) == 0);
            got = {iss_valid, disp_ready, iss_alu_fn, iss_op1, iss_op2, iss_immediate, iss_dest_tag};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_cyc%0d got %h exp %h", c, got, exp);
            end
            tick();
        end
        iss_ready = 0;
        flush = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        drive_disp(6'h0A, 16'h0, 1, 1, 32'd11, 4'd0, 0, 0, 32'd0, 4'd0, 4'd1);
        tick();
        drive_disp(6'h0A, 16'h0, 1, 1, 32'd12, 4'd0, 0, 0, 32'd0, 4'd0, 4'd2);
        tick();
        #2;
        rst_n = 0;
        #1;
        mq.delete();
        checks++;
        if ({iss_valid, disp_ready, iss_op1, iss_dest_tag} !== {1'b0, 1'b1, 32'd0, 4'd0}) begin
            errors++; $display("FAIL reset_mid got vld=%0b rdy=%0b op1=%0d exp 0/1/0", iss_valid, disp_ready, iss_op1);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if ({iss_valid, disp_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_after got vld=%0b rdy=%0b exp 0/1", iss_valid, disp_ready);
        end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_wakeup();
        test_full();
        test_age();
        test_filter();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
